// File: rtl/ncl_sync_tx_pkg.sv
// ============================================================================
// ncl_pkg : shared types and helpers for the clocked-to-NCL transmitter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package ncl_pkg;

    // Transmitter FSM: idle, DATA wavefront outstanding, NULL wavefront outstanding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        NULL = 2'd2
    } ncl_tx_state_e;

    // One dual-rail bit; {1,1} is illegal on the channel
    typedef struct packed {
        logic rail1;
        logic rail0;
    } ncl_dr_t;

    // Value of every rail while the channel carries NULL
    localparam logic NCL_NULL = '0;

    // Dual-rail encode of one data bit; callers map it across a word
    function automatic ncl_dr_t dr_encode(input logic word);
        ncl_dr_t dr;
        dr.rail1 = word;
        dr.rail0 = ~word;
        return dr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ncl_sync_tx_if.sv
// ============================================================================
// ncl_sync_tx_if : valid/ready source side plus dual-rail NCL channel
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface ncl_sync_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ki;
    logic [WIDTH-1:0] rail1;
    logic [WIDTH-1:0] rail0;

    // master: the transmitter; slave: the source plus NCL receiver around it
    modport master (
        input  in_valid,
        input  in_data,
        input  ki,
        output in_ready,
        output rail1,
        output rail0
    );

    modport slave (
        output in_valid,
        output in_data,
        output ki,
        input  in_ready,
        input  rail1,
        input  rail0
    );
endinterface

`default_nettype wire

// File: rtl/ncl_sync_tx_ack_sync.sv
// ============================================================================
// ncl_ack_sync : multi-flop synchronizer for the NCL completion acknowledge
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ncl_ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] stages;

    // Resets to 0 so the sender never sees a spurious RFD out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = stages[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/ncl_sync_tx.sv
// ============================================================================
// ncl_sync_tx : launches valid/ready words as DATA/NULL wavefronts on NCL rails
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ncl_sync_tx
    import ncl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    ncl_sync_tx_if.master bus,
    output logic          busy,
    output logic          err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    ncl_tx_state_e    state;
    logic             ki_s;
    logic [CNT_W-1:0] wait_cnt;
    logic             cnt_sat;
    logic             accept;
    logic [WIDTH-1:0] enc_rail1;
    logic [WIDTH-1:0] enc_rail0;
    logic [WIDTH-1:0] tx_rail1;
    logic [WIDTH-1:0] tx_rail0;

    ncl_ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.ki),
        .sync_out (ki_s)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_enc
        ncl_dr_t dr;
        assign dr           = dr_encode(bus.in_data[i]);
        assign enc_rail1[i] = dr.rail1;
        assign enc_rail0[i] = dr.rail0;
    end

    assign bus.in_ready = (state == IDLE) && ki_s;
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state != IDLE);
    assign cnt_sat      = (wait_cnt == TMO_MAX);

    // Rails are only ever loaded as a full word or cleared as a full word,
    // so the receiver never observes a partial wavefront.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_rail1 <= {WIDTH{NCL_NULL}};
            tx_rail0 <= {WIDTH{NCL_NULL}};
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (accept) begin
                        tx_rail1 <= enc_rail1;
                        tx_rail0 <= enc_rail0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (!ki_s) begin
                        tx_rail1 <= {WIDTH{NCL_NULL}};
                        tx_rail0 <= {WIDTH{NCL_NULL}};
                        wait_cnt <= '0;
                        state    <= NULL;
                    end else begin
                        if (!cnt_sat) wait_cnt <= wait_cnt + CNT_W'(1);
                        if (wait_cnt == TMO_LAST) err <= 1'b1;
                    end
                end
                NULL: begin
                    if (ki_s) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        if (!cnt_sat) wait_cnt <= wait_cnt + CNT_W'(1);
                        if (wait_cnt == TMO_LAST) err <= 1'b1;
                    end
                end
                default: begin
                    tx_rail1 <= {WIDTH{NCL_NULL}};
                    tx_rail0 <= {WIDTH{NCL_NULL}};
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.rail1 = tx_rail1;
    assign bus.rail0 = tx_rail0;

endmodule

`default_nettype wire

// File: tb/tb_ncl_sync_tx.sv
// ============================================================================
// tb_ncl_sync_tx : directed self-checking bench for ncl_sync_tx
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ncl_sync_tx;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    logic busy;
    logic err;
    int   checks;
    int   failures;

    ncl_sync_tx_if #(.WIDTH(WIDTH)) bus ();

    ncl_sync_tx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .TIMEOUT     (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ki = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        tick(3);
        checks++;
        if (bus.rail1 !== 8'h00 || bus.rail0 !== 8'h00) begin
            failures++;
            $display("FAIL reset_rails: got %h/%h expected 00/00", bus.rail1, bus.rail0);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got busy=%b err=%b rdy=%b expected 0/0/0", busy, err, bus.in_ready);
        end
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_edge1: got %b expected 0", bus.in_ready);
        end
        tick(1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_edge2: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_single_word();
        bus.in_data = 8'hA5;
        bus.in_valid = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.rail1 !== 8'hA5 || bus.rail0 !== 8'h5A) begin
            failures++;
            $display("FAIL a5_data: got %h/%h expected a5/5a", bus.rail1, bus.rail0);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL a5_busy: got rdy=%b busy=%b expected 0/1", bus.in_ready, busy);
        end
        tick(2);
        bus.ki = 1'b0;
        tick(2);
        checks++;
        if (bus.rail1 !== 8'hA5 || bus.rail0 !== 8'h5A) begin
            failures++;
            $display("FAIL a5_hold: got %h/%h expected a5/5a", bus.rail1, bus.rail0);
        end
        tick(1);
        checks++;
        if (bus.rail1 !== 8'h00 || bus.rail0 !== 8'h00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL a5_null: got %h/%h busy=%b expected 00/00 busy=1", bus.rail1, bus.rail0, busy);
        end
        tick(2);
        bus.ki = 1'b1;
        tick(2);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL a5_rdy_early: got %b expected 0", bus.in_ready);
        end
        tick(1);
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL a5_rdy: got rdy=%b busy=%b expected 1/0", bus.in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic [7:0] seen  [3];
        int  idx;
        int  got;
        int  dly;
        bit  acc;
        bit  is_null;
        bit  prev_null;
        bit  done;
        words[0] = 8'h00;
        words[1] = 8'hFF;
        words[2] = 8'h3C;
        seen[0] = 8'hxx;
        seen[1] = 8'hxx;
        seen[2] = 8'hxx;
        idx = 0;
        got = 0;
        dly = 0;
        prev_null = 1'b1;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = words[0];
        for (int cyc = 0; cyc < 200; cyc++) begin
            acc = bus.in_ready && bus.in_valid;
            tick(1);
            if (acc) begin
                idx++;
                if (idx < 3) bus.in_data = words[idx];
                else bus.in_valid = 1'b0;
            end
            checks++;
            if ((bus.rail1 & bus.rail0) !== 8'h00) begin
                failures++;
                $display("FAIL b2b_overlap: got %h expected 00", bus.rail1 & bus.rail0);
            end
            is_null = (bus.rail1 == 8'h00) && (bus.rail0 == 8'h00);
            if (!is_null && prev_null) begin
                if (got < 3) seen[got] = bus.rail1;
                got++;
            end
            prev_null = is_null;
            if (!is_null && bus.ki) begin
                dly++;
                if (dly == 3) begin bus.ki = 1'b0; dly = 0; end
            end else if (is_null && !bus.ki) begin
                dly++;
                if (dly == 3) begin bus.ki = 1'b1; dly = 0; end
            end else begin
                dly = 0;
            end
            if (idx == 3 && busy == 1'b0 && bus.ki) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done || got != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d wavefronts done=%0d expected 3 done=1", got, done);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (seen[k] !== words[k]) begin
                failures++;
                $display("FAIL b2b_word%0d: got %h expected %h", k, seen[k], words[k]);
            end
        end
    endtask

    task automatic test_data_hold();
        bus.in_data = 8'h96;
        bus.in_valid = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
        bus.in_data = 8'h11;
        tick(3);
        checks++;
        if (bus.rail1 !== 8'h96 || bus.rail0 !== 8'h69) begin
            failures++;
            $display("FAIL hold_data: got %h/%h expected 96/69", bus.rail1, bus.rail0);
        end
        bus.ki = 1'b0;
        tick(3);
        bus.ki = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b0 || bus.rail1 !== 8'h00 || bus.rail0 !== 8'h00) begin
            failures++;
            $display("FAIL hold_done: got busy=%b rails=%h/%h expected 0 00/00", busy, bus.rail1, bus.rail0);
        end
    endtask

    task automatic test_timeout();
        bus.in_data = 8'h42;
        bus.in_valid = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
        tick(15);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_early: got %b expected 0", err);
        end
        tick(1);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_set: got %b expected 1", err);
        end
        checks++;
        if (bus.rail1 !== 8'h42 || bus.rail0 !== 8'hBD || busy !== 1'b1) begin
            failures++;
            $display("FAIL tmo_rails: got %h/%h busy=%b expected 42/bd busy=1", bus.rail1, bus.rail0, busy);
        end
        bus.ki = 1'b0;
        tick(3);
        checks++;
        if (bus.rail1 !== 8'h00 || bus.rail0 !== 8'h00 || err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_null: got %h/%h err=%b expected 00/00 err=1", bus.rail1, bus.rail0, err);
        end
        bus.ki = 1'b1;
        tick(3);
        checks++;
        if (bus.in_ready !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_done: got rdy=%b err=%b expected 1/1", bus.in_ready, err);
        end
    endtask

    task automatic test_async_reset();
        bus.in_data = 8'h81;
        bus.in_valid = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.rail1 !== 8'h81 || bus.rail0 !== 8'h7E) begin
            failures++;
            $display("FAIL rst_data: got %h/%h expected 81/7e", bus.rail1, bus.rail0);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rail1 !== 8'h00 || bus.rail0 !== 8'h00) begin
            failures++;
            $display("FAIL rst_rails: got %h/%h expected 00/00", bus.rail1, bus.rail0);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_state: got busy=%b err=%b rdy=%b expected 0/0/0", busy, err, bus.in_ready);
        end
        tick(1);
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_rdy1: got %b expected 0", bus.in_ready);
        end
        tick(1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_rdy2: got %b expected 1", bus.in_ready);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_data_hold();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
